// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one sync-read RAM between CPU (port 0) and loader (port 1); req->ack latency 2 cycles, 3 cycles per access.
// One access in flight; losers hold req until ack. Define MEM_ARB_LOCK_EN to honour lock0/lock1 (grant hold), otherwise they are ignored.
module mem_port_arbiter #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          we0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    input  logic          we1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    input  logic          lock0,
    input  logic          lock1,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          last_q, last_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_we_q, mem_we_d;

    logic          win_vld;
    logic          win_port;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;
    logic          win_we;

`ifdef MEM_ARB_LOCK_EN
    logic          lock_hold_q, lock_hold_d;
    logic          hold_act;

    // The hold only binds while the held port is still asking; otherwise it is released.
    assign hold_act = lock_hold_q && (gnt_q ? req1 : req0);
`else
    logic          unused_lock;

    assign unused_lock = lock0 ^ lock1;
`endif

    always_comb begin
        win_vld  = req0 | req1;
        win_port = 1'b0;
        if (req0 && req1) begin
            win_port = ~last_q;
        end else if (req1) begin
            win_port = 1'b1;
        end
`ifdef MEM_ARB_LOCK_EN
        if (hold_act) begin
            win_vld  = 1'b1;
            win_port = gnt_q;
        end
`endif
    end

    assign win_addr  = win_port ? addr1  : addr0;
    assign win_wdata = win_port ? wdata1 : wdata0;
    assign win_we    = win_port ? we1    : we0;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
`ifdef MEM_ARB_LOCK_EN
        lock_hold_d = lock_hold_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef MEM_ARB_LOCK_EN
                lock_hold_d = 1'b0;
`endif
                if (win_vld) begin
                    mem_addr_d  = win_addr;
                    mem_wdata_d = win_wdata;
                    mem_we_d    = win_we;
                    gnt_d       = win_port;
                    last_d      = win_port;
                    state_d     = ST_ACC;
                end else begin
                    mem_we_d    = 1'b0;
                end
            end
            ST_ACC: begin
                // Write strobe lives for the ACC cycle only.
                mem_we_d = 1'b0;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
`ifdef MEM_ARB_LOCK_EN
                lock_hold_d = gnt_q ? lock1 : lock0;
`endif
                state_d = ST_IDLE;
            end
            default: begin
                mem_we_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 1'b0;
            last_q      <= 1'b1;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
`ifdef MEM_ARB_LOCK_EN
            lock_hold_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
`ifdef MEM_ARB_LOCK_EN
            lock_hold_q <= lock_hold_d;
`endif
        end
    end

    // RAM read data arrives in RESP and is steered straight to the granted port.
    assign ack0      = (state_q == ST_RESP) && !gnt_q;
    assign ack1      = (state_q == ST_RESP) &&  gnt_q;
    assign rdata0    = ack0 ? mem_rdata : '0;
    assign rdata1    = ack1 ? mem_rdata : '0;
    assign busy      = (state_q != ST_IDLE);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected acks/data, a negedge monitor pops and compares.
module tb_mem_port_arbiter;
    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, we0, lock0, req1, we1, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, mem_we, busy;
    logic [DW-1:0] rdata0, rdata1, mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [AW-1:0] mem_addr;

    typedef struct {
        bit          rd;
        logic [15:0] dat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    bit   ord_q[$];
    int   total = 0;
    int   bad = 0;

    logic [DW-1:0] ram [0:255];
    bit            ram_loaded = 1'b0;
    logic          we_prev = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .wdata0(wdata0), .we0(we0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1), .ack1(ack1), .rdata1(rdata1),
        .lock0(lock0), .lock1(lock1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    // Synchronous-read RAM; default contents ram[i] = i, plus two marker words.
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 256; i++) ram[i] <= 16'(i);
            ram[5]     <= 16'hBEEF;
            ram[3]     <= 16'hCAFE;
            ram_loaded <= 1'b1;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit   p;
        if (!reset) begin
            if (ack0 || ack1) begin
                check("ack_exclusive", 32'(ack0 && ack1), 32'd0);
                if (ord_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ack: got ack0=%b ack1=%b expected none at %0t", ack0, ack1, $time);
                end else begin
                    p = ord_q.pop_front();
                    check("grant_order", 32'(ack1), 32'(p));
                    if (ack1 && q1.size() > 0) begin
                        e = q1.pop_front();
                        if (e.rd) check("rdata1", 32'(rdata1), 32'(e.dat));
                        check("rdata0_idle", 32'(rdata0), 32'd0);
                    end else if (ack0 && q0.size() > 0) begin
                        e = q0.pop_front();
                        if (e.rd) check("rdata0", 32'(rdata0), 32'(e.dat));
                        check("rdata1_idle", 32'(rdata1), 32'd0);
                    end
                end
            end
            if (mem_we) check("mem_we_single", 32'(we_prev), 32'd0);
        end
        we_prev <= mem_we;
    end

    task automatic acc0(input bit we, input logic [7:0] a, input logic [15:0] d, input bit lk, input bit keep);
        int n = 0;
        req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; lock0 = lk;
        do begin
            @(negedge clk);
            n++;
        end while (!ack0 && n < 20);
        if (!ack0) begin
            total++;
            bad++;
            $display("FAIL ack0_timeout: got no ack expected ack within 20 cycles");
        end
        @(negedge clk);
        if (!keep) begin
            req0 = 1'b0; lock0 = 1'b0;
        end
    endtask

    task automatic acc1(input bit we, input logic [7:0] a, input logic [15:0] d, input bit lk, input bit keep);
        int n = 0;
        req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; lock1 = lk;
        do begin
            @(negedge clk);
            n++;
        end while (!ack1 && n < 20);
        if (!ack1) begin
            total++;
            bad++;
            $display("FAIL ack1_timeout: got no ack expected ack within 20 cycles");
        end
        @(negedge clk);
        if (!keep) begin
            req1 = 1'b0; lock1 = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0; lock0 = 0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0; lock1 = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack0", 32'(ack0), 32'd0);
        check("rst_ack1", 32'(ack1), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_rdata0", 32'(rdata0), 32'd0);
        check("rst_rdata1", 32'(rdata1), 32'd0);
        reset = 1'b0;

        // Read of BEEF at address 5 through port 0.
        q0.push_back('{1'b1, 16'hBEEF});
        ord_q.push_back(1'b0);
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h05;
        @(negedge clk);
        check("t1_mem_addr", 32'(mem_addr), 32'h05);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_mem_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        @(negedge clk);
        req0 = 1'b0;
        check("t1_idle", 32'(busy), 32'd0);

        // Port 1 write, then port 0 readback.
        q1.push_back('{1'b0, 16'h0000});
        ord_q.push_back(1'b1);
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h10; wdata1 = 16'h1234;
        @(negedge clk);
        check("t2_mem_we_acc", 32'(mem_we), 32'd1);
        check("t2_mem_addr", 32'(mem_addr), 32'h10);
        check("t2_mem_wdata", 32'(mem_wdata), 32'h1234);
        @(negedge clk);
        check("t2_mem_we_resp", 32'(mem_we), 32'd0);
        @(negedge clk);
        req1 = 1'b0; we1 = 1'b0;
        q0.push_back('{1'b1, 16'h1234});
        ord_q.push_back(1'b0);
        acc0(1'b0, 8'h10, 16'h0, 1'b0, 1'b0);

        // Both ports continuously requesting from reset: 0,1,0,1.
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ord_q.push_back(1'b0); ord_q.push_back(1'b1);
        ord_q.push_back(1'b0); ord_q.push_back(1'b1);
        q0.push_back('{1'b1, 16'h0007}); q0.push_back('{1'b1, 16'h0008});
        q1.push_back('{1'b1, 16'h0009}); q1.push_back('{1'b1, 16'h000A});
        fork
            begin
                acc0(1'b0, 8'h07, 16'h0, 1'b0, 1'b1);
                acc0(1'b0, 8'h08, 16'h0, 1'b0, 1'b0);
            end
            begin
                acc1(1'b0, 8'h09, 16'h0, 1'b0, 1'b1);
                acc1(1'b0, 8'h0A, 16'h0, 1'b0, 1'b0);
            end
        join
        repeat (2) @(negedge clk);

        // Port 0 drops req and scrambles its inputs during ACC; the latched read still completes.
        q0.push_back('{1'b1, 16'hCAFE});
        ord_q.push_back(1'b0);
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h03;
        @(negedge clk);
        req0 = 1'b0; addr0 = 8'hFF; we0 = 1'b1;
        check("t6_mem_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        @(negedge clk);
        we0 = 1'b0;
        check("t6_idle", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);

        // Reset lands during ACC of a port 1 write: no ack, write strobe gone.
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h20; wdata1 = 16'h5555;
        @(negedge clk);
        check("t4_mem_we_acc", 32'(mem_we), 32'd1);
        reset = 1'b1; req1 = 1'b0; we1 = 1'b0;
        @(negedge clk);
        check("t4_mem_we", 32'(mem_we), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_ack1", 32'(ack1), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // lock0 on port 0's first access: hold gives 0,0,1; without the feature plain 0,1,0.
`ifdef MEM_ARB_LOCK_EN
        ord_q.push_back(1'b0); ord_q.push_back(1'b0); ord_q.push_back(1'b1);
`else
        ord_q.push_back(1'b0); ord_q.push_back(1'b1); ord_q.push_back(1'b0);
`endif
        q0.push_back('{1'b1, 16'h0007}); q0.push_back('{1'b1, 16'h0008});
        q1.push_back('{1'b1, 16'h0009});
        fork
            begin
                acc0(1'b0, 8'h07, 16'h0, 1'b1, 1'b1);
                acc0(1'b0, 8'h08, 16'h0, 1'b0, 1'b0);
            end
            begin
                acc1(1'b0, 8'h09, 16'h0, 1'b0, 1'b0);
            end
        join
        repeat (3) @(negedge clk);

        check("pending_expectations", 32'(q0.size() + q1.size() + ord_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
